// File: rtl/jtag_reg_bank_pkg.sv
// jtag_reg_bank_pkg: FSM state encoding and DR sizing helpers shared by the JTAG register bank
//   jtag_state_e : IDLE / CAPT / SHIFT / UPD transaction states
//   addr_width() : address field width, never below one bit
//   dr_length()  : full DR frame length = wr bit + address + data
package jtag_reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_UPD   = 2'd3
    } jtag_state_e;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int dr_length(input int data_w, input int n);
        return 1 + addr_width(n) + data_w;
    endfunction

endpackage

// File: rtl/jtag_reg_bank_shift_dr.sv
// jtag_reg_bank_shift_dr: DR shift register with parallel load and saturating bit counter
//   i_tck/i_resetn : TCK and async active-low reset
//   i_load/i_load_val : parallel capture, clears the counter (beats shift and clear)
//   i_shift/i_tdi  : shift one bit in at the top, LSB leaves first
//   i_clr          : clear the counter once a frame has been consumed
//   o_sr/o_cnt     : register contents and bits shifted since capture (saturates at DR_LEN+1)
module jtag_reg_bank_shift_dr #(
    parameter  int DR_LEN = 11,
    localparam int CNT_W  = $clog2(DR_LEN + 2)
)(
    input  logic              i_tck,
    input  logic              i_resetn,
    input  logic              i_load,
    input  logic [DR_LEN-1:0] i_load_val,
    input  logic              i_shift,
    input  logic              i_clr,
    input  logic              i_tdi,
    output logic [DR_LEN-1:0] o_sr,
    output logic [CNT_W-1:0]  o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DR_LEN + 1);

    logic [DR_LEN-1:0] r_sr;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge i_tck or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_load_val;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= {i_tdi, r_sr[DR_LEN-1:1]};
            r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end else if (i_clr) begin
            r_cnt <= '0;
        end
    end

    assign o_sr  = r_sr;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/jtag_reg_bank.sv
// jtag_reg_bank: JTAG user-DR register bank (TCK domain) with addressed writes and readback
//   i_tck/i_resetn          : TCK and async active-low reset
//   i_sel/i_capture/i_shift/i_update/i_tdi : BSCANE2 TAP outputs, ignored while i_sel=0
//   o_tdo                   : serial out, bit 0 of the DR
//   i_rd_data               : per-channel readback, channel i at [i*JDATA_WIDTH +: JDATA_WIDTH]
//   o_reg_q/o_wr_strobe     : written register values and one-cycle write pulses
//   o_rd_addr               : channel returned by the next capture
//   o_frame_err/o_addr_err  : bad frame length / out-of-range address on the last update
// DR layout, bit 0 shifted first: data, then address, then wr at the top bit.
module jtag_reg_bank
    import jtag_reg_bank_pkg::*;
#(
    parameter  int                     JDATA_WIDTH = 32,
    parameter  int                     NUM_REGS    = 4,
    parameter  logic [JDATA_WIDTH-1:0] RESET_VALUE = '0,
    localparam int                     ADDR_W      = addr_width(NUM_REGS)
)(
    input  logic                            i_tck,
    input  logic                            i_resetn,
    input  logic                            i_sel,
    input  logic                            i_capture,
    input  logic                            i_shift,
    input  logic                            i_update,
    input  logic                            i_tdi,
    output logic                            o_tdo,
    input  logic [NUM_REGS*JDATA_WIDTH-1:0] i_rd_data,
    output logic [NUM_REGS*JDATA_WIDTH-1:0] o_reg_q,
    output logic [NUM_REGS-1:0]             o_wr_strobe,
    output logic [ADDR_W-1:0]               o_rd_addr,
    output logic                            o_frame_err,
    output logic                            o_addr_err
);

    localparam int                DR_LEN     = dr_length(JDATA_WIDTH, NUM_REGS);
    localparam int                CNT_W      = $clog2(DR_LEN + 2);
    localparam int                ADDR_LSB   = JDATA_WIDTH;
    localparam int                WR_BIT     = DR_LEN - 1;
    localparam logic [ADDR_W:0]   NUM_REGS_V = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [CNT_W-1:0]  DR_LEN_V   = CNT_W'(DR_LEN);

    jtag_state_e            r_state, w_state_nx;
    logic                   r_upd_d, w_upd_rise, w_load, w_shift_en;
    logic                   w_len_ok, w_addr_ok, w_wr_en;
    logic                   r_frame_err, r_addr_err;
    logic [DR_LEN-1:0]      w_sr, w_cap_val;
    logic [CNT_W-1:0]       w_cnt;
    logic [ADDR_W-1:0]      w_addr, r_rd_addr;
    logic [JDATA_WIDTH-1:0] w_data;
    logic [JDATA_WIDTH-1:0] w_rd_ch [2**ADDR_W];
    logic [NUM_REGS-1:0]    w_wr_dec, r_wr_strobe;

    // Readback mux is padded to a power of two so any address value indexes safely
    for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_ch
        if (g < NUM_REGS) begin : g_real
            logic [JDATA_WIDTH-1:0] r_q;
            assign w_rd_ch[g]  = i_rd_data[g*JDATA_WIDTH +: JDATA_WIDTH];
            assign w_wr_dec[g] = w_wr_en && (w_addr == ADDR_W'(g));
            assign o_reg_q[g*JDATA_WIDTH +: JDATA_WIDTH] = r_q;
            always_ff @(posedge i_tck or negedge i_resetn) begin
                if (!i_resetn)
                    r_q <= RESET_VALUE;
                else if (w_wr_dec[g])
                    r_q <= w_data;
            end
        end else begin : g_pad
            assign w_rd_ch[g] = '0;
        end
    end

    assign w_cap_val  = {r_frame_err | r_addr_err, r_rd_addr, w_rd_ch[r_rd_addr]};
    assign w_upd_rise = i_sel && i_update && !r_upd_d;
    assign w_load     = i_sel && i_capture;
    // Capture beats shift, update beats shift; shifting outside a frame is ignored
    assign w_shift_en = i_sel && i_shift && !i_capture && !w_upd_rise &&
                        (r_state == ST_CAPT || r_state == ST_SHIFT);

    jtag_reg_bank_shift_dr #(.DR_LEN(DR_LEN)) u_shift_dr (
        .i_tck      (i_tck),
        .i_resetn   (i_resetn),
        .i_load     (w_load),
        .i_load_val (w_cap_val),
        .i_shift    (w_shift_en),
        // Clearing on UPD makes a later update without capture read as a bad frame
        .i_clr      (r_state == ST_UPD),
        .i_tdi      (i_tdi),
        .o_sr       (w_sr),
        .o_cnt      (w_cnt)
    );

    assign w_data    = w_sr[JDATA_WIDTH-1:0];
    assign w_addr    = w_sr[ADDR_LSB +: ADDR_W];
    assign w_len_ok  = (w_cnt == DR_LEN_V);
    assign w_addr_ok = ({1'b0, w_addr} < NUM_REGS_V);
    assign w_wr_en   = (r_state == ST_UPD) && w_len_ok && w_addr_ok && w_sr[WR_BIT];

    always_comb begin
        w_state_nx = r_state;
        if (w_load)
            w_state_nx = ST_CAPT;
        else if (w_upd_rise)
            w_state_nx = ST_UPD;
        else if (r_state == ST_UPD)
            w_state_nx = ST_IDLE;
        else if (w_shift_en)
            w_state_nx = ST_SHIFT;
    end

    always_ff @(posedge i_tck or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= ST_IDLE;
            r_upd_d     <= 1'b0;
            r_wr_strobe <= '0;
            r_rd_addr   <= '0;
            r_frame_err <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_upd_d     <= i_update;
            r_wr_strobe <= w_wr_dec;
            if (r_state == ST_UPD) begin
                r_frame_err <= !w_len_ok;
                if (w_len_ok) begin
                    r_addr_err <= !w_addr_ok;
                    if (w_addr_ok)
                        r_rd_addr <= w_addr;
                end
            end
        end
    end

    assign o_tdo       = w_sr[0];
    assign o_wr_strobe = r_wr_strobe;
    assign o_rd_addr   = r_rd_addr;
    assign o_frame_err = r_frame_err;
    assign o_addr_err  = r_addr_err;

endmodule

// File: tb/tb_jtag_reg_bank.sv
// tb_jtag_reg_bank: directed checks of the JTAG register bank (4-channel and 3-channel builds)
module tb_jtag_reg_bank;

    localparam int W = 8;

    logic tck = 1'b0, resetn = 1'b0;
    logic sel = 1'b0, capture = 1'b0, shift = 1'b0, update = 1'b0, tdi = 1'b0, tgt = 1'b0;
    logic sel4, sel3;
    logic [4*W-1:0] rd_data4 = '0, reg_q4;
    logic [3*W-1:0] rd_data3 = '0, reg_q3;
    logic [3:0] wr_strobe4;
    logic [2:0] wr_strobe3;
    logic [1:0] rd_addr4, rd_addr3;
    logic tdo4, tdo3, ferr4, ferr3, aerr4, aerr3;
    logic [11:0] tdo_seq;
    logic tdo_hold;
    int total = 0, bad = 0;

    always #5 tck = ~tck;

    assign sel4 = sel & ~tgt;
    assign sel3 = sel & tgt;

    jtag_reg_bank #(.JDATA_WIDTH(W), .NUM_REGS(4), .RESET_VALUE(8'h00)) u4 (
        .i_tck(tck), .i_resetn(resetn), .i_sel(sel4), .i_capture(capture), .i_shift(shift),
        .i_update(update), .i_tdi(tdi), .o_tdo(tdo4), .i_rd_data(rd_data4), .o_reg_q(reg_q4),
        .o_wr_strobe(wr_strobe4), .o_rd_addr(rd_addr4), .o_frame_err(ferr4), .o_addr_err(aerr4)
    );

    jtag_reg_bank #(.JDATA_WIDTH(W), .NUM_REGS(3), .RESET_VALUE(8'h00)) u3 (
        .i_tck(tck), .i_resetn(resetn), .i_sel(sel3), .i_capture(capture), .i_shift(shift),
        .i_update(update), .i_tdi(tdi), .o_tdo(tdo3), .i_rd_data(rd_data3), .o_reg_q(reg_q3),
        .o_wr_strobe(wr_strobe3), .o_rd_addr(rd_addr3), .o_frame_err(ferr3), .o_addr_err(aerr3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge tck);
        #1;
    endtask

    // capture, n shifts of v LSB first (recording tdo before each shift), update, then the UPD edge
    task automatic run_frame(input logic [11:0] v, input int n);
        tdo_seq = '0;
        sel = 1'b1;
        capture = 1'b1;
        cyc();
        capture = 1'b0;
        shift = 1'b1;
        for (int i = 0; i < n; i++) begin
            tdo_seq[i] = tgt ? tdo3 : tdo4;
            tdi = v[i];
            cyc();
        end
        shift = 1'b0;
        update = 1'b1;
        cyc();
        update = 1'b0;
        cyc();
    endtask

    initial begin
        cyc();
        cyc();
        check("por_tdo", tdo4, 1'b0);
        check("por_regq", reg_q4, 32'h0);
        check("por_errs", {ferr4, aerr4}, 2'b00);
        resetn = 1'b1;
        cyc();

        // write ch2 = A5
        run_frame(12'h6A5, 11);
        check("wr_regq", reg_q4, 32'h00A5_0000);
        check("wr_strobe", wr_strobe4, 4'b0100);
        check("wr_rdaddr", rd_addr4, 2'd2);
        check("wr_errs", {ferr4, aerr4}, 2'b00);
        cyc();
        check("wr_strobe_drop", wr_strobe4, 4'b0000);

        // read ch2 with readback 3C
        rd_data4[23:16] = 8'h3C;
        run_frame(12'h200, 11);
        check("rd_tdo", tdo_seq[10:0], 11'h23C);
        check("rd_strobe", wr_strobe4, 4'b0000);
        check("rd_regq", reg_q4, 32'h00A5_0000);

        // short frame
        run_frame(12'h6FF, 10);
        check("short_regq", reg_q4, 32'h00A5_0000);
        check("short_strobe", wr_strobe4, 4'b0000);
        check("short_ferr", ferr4, 1'b1);
        check("short_aerr", aerr4, 1'b0);
        check("short_rdaddr", rd_addr4, 2'd2);

        // next capture carries the error bit; valid frame clears it
        run_frame(12'h200, 11);
        check("err_tdo", tdo_seq[10:0], 11'h63C);
        check("err_clear", ferr4, 1'b0);

        // overlength frame
        run_frame(12'hFFF, 12);
        check("long_ferr", ferr4, 1'b1);
        check("long_regq", reg_q4, 32'h00A5_0000);
        check("long_strobe", wr_strobe4, 4'b0000);
        run_frame(12'h200, 11);
        check("long_clear", ferr4, 1'b0);

        // update with no capture
        update = 1'b1;
        cyc();
        update = 1'b0;
        cyc();
        check("bare_upd_ferr", ferr4, 1'b1);
        check("bare_upd_regq", reg_q4, 32'h00A5_0000);

        // sel low: whole sequence ignored
        tdo_hold = tdo4;
        sel = 1'b0;
        capture = 1'b1;
        cyc();
        capture = 1'b0;
        shift = 1'b1;
        tdi = 1'b1;
        repeat (11) cyc();
        shift = 1'b0;
        update = 1'b1;
        cyc();
        update = 1'b0;
        cyc();
        check("nosel_tdo", tdo4, tdo_hold);
        check("nosel_regq", reg_q4, 32'h00A5_0000);
        check("nosel_strobe", wr_strobe4, 4'b0000);
        check("nosel_ferr", ferr4, 1'b1);

        // reset in the middle of a write frame
        sel = 1'b1;
        capture = 1'b1;
        cyc();
        capture = 1'b0;
        shift = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tdi = i[0];
            cyc();
        end
        #2 resetn = 1'b0;
        #1;
        check("rst_tdo", tdo4, 1'b0);
        check("rst_regq", reg_q4, 32'h0);
        check("rst_strobe", wr_strobe4, 4'b0000);
        check("rst_rdaddr", rd_addr4, 2'd0);
        check("rst_errs", {ferr4, aerr4}, 2'b00);
        shift = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
        cyc();
        run_frame(12'h55A, 11);
        check("post_rst_regq", reg_q4, 32'h0000_5A00);
        check("post_rst_strobe", wr_strobe4, 4'b0010);
        check("post_rst_rdaddr", rd_addr4, 2'd1);
        check("post_rst_errs", {ferr4, aerr4}, 2'b00);

        // three-channel build: out-of-range address
        tgt = 1'b1;
        run_frame(12'h511, 11);
        check("n3_wr_regq", reg_q3, 24'h00_1100);
        check("n3_wr_strobe", wr_strobe3, 3'b010);
        check("n3_wr_rdaddr", rd_addr3, 2'd1);
        run_frame(12'h7FF, 11);
        check("n3_bad_strobe", wr_strobe3, 3'b000);
        check("n3_bad_regq", reg_q3, 24'h00_1100);
        check("n3_bad_aerr", aerr3, 1'b1);
        check("n3_bad_ferr", ferr3, 1'b0);
        check("n3_bad_rdaddr", rd_addr3, 2'd1);
        run_frame(12'h200, 11);
        check("n3_rd_tdo", tdo_seq[10:0], 11'h500);
        check("n3_clear_aerr", aerr3, 1'b0);
        check("n3_rd_rdaddr", rd_addr3, 2'd2);
        check("n4_untouched", reg_q4, 32'h0000_5A00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
